// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared definitions for the PISO transmit controller.
//   state_t    : controller state encoding (IDLE / SHIFT / PARITY)
//   LSB_FIRST  : serialisation order of the shift path (1 = LSB first)
package piso_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_tx_ctrl_if.sv
// piso_tx_ctrl_if: word-in / bit-out bundle of the PISO transmit controller.
//   in_data/in_valid/in_ready : parallel word handshake from the producer
//   ser_en                    : downstream consumes the current bit (stall when 0)
//   ser_out/ser_valid         : serial bit and its qualifier
//   ser_first/ser_last        : frame markers
// Modports: slave = the controller, master = the producer/link side.
interface piso_tx_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;

    modport slave (
        input  in_data, in_valid, ser_en,
        output in_ready, ser_out, ser_valid, ser_first, ser_last
    );

    modport master (
        output in_data, in_valid, ser_en,
        input  in_ready, ser_out, ser_valid, ser_first, ser_last
    );
endinterface

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: WIDTH-bit parallel-load shift register.
//   clk, rst : clock, synchronous active-high reset (clears the register)
//   load, d  : parallel load, priority over shift
//   shift    : advance one bit toward the output end
//   q0       : bit currently at the output end
module piso_shift_reg
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] r_sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (load) begin
            r_sreg <= d;
        end else if (shift) begin
            if (LSB_FIRST) r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
            else           r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign q0 = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: accepts parallel words on a valid/ready handshake and sends
// them LSB first, one bit per ser_en cycle, with first/last frame markers and
// back-to-back frames without an idle cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : piso_tx_ctrl_if.slave (word handshake + serial side)
//   busy     : a frame is in progress
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// after the data bits of every frame.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | no frame; in_ready=1, waiting for a word
// ST_SHIFT  | data bit r_cnt of the current word on ser_out
// ST_PARITY | parity bit on ser_out (PISO_TX_PARITY_EN only)
module piso_tx_ctrl
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    piso_tx_ctrl_if.slave   bus,
    output logic            busy
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;
    logic             w_shift;
    logic [WIDTH-1:0] w_load_data;
    logic             w_q0;
    logic             w_ready;
    logic             w_ser_valid;
    logic             w_ser_out;
    logic             w_first;
    logic             w_last;
    logic             w_frame_end;

    piso_shift_reg #(.WIDTH(WIDTH)) u_sreg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .d     (w_load_data),
        .q0    (w_q0)
    );

`ifdef PISO_TX_PARITY_EN
    logic r_par;

    // Parity is taken from the word as it is loaded; the clear-load at frame
    // end leaves it at 0, which is never shown.
    always_ff @(posedge clk) begin
        if (rst)         r_par <= 1'b0;
        else if (w_load) r_par <= ^w_load_data;
    end

    assign w_frame_end = bus.ser_en && (r_state == ST_PARITY);
`else
    assign w_frame_end = bus.ser_en && (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_load_data = bus.in_data;
        w_ready     = 1'b0;
        w_ser_valid = 1'b0;
        w_ser_out   = 1'b0;
        w_first     = 1'b0;
        w_last      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready = !rst;
                if (bus.in_valid && !rst) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_ser_valid = 1'b1;
                w_ser_out   = w_q0;
                w_first     = (r_cnt == '0);
`ifndef PISO_TX_PARITY_EN
                w_last      = (r_cnt == CNT_LAST);
`endif
                if (bus.ser_en && (r_cnt != CNT_LAST)) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`ifdef PISO_TX_PARITY_EN
                else if (bus.ser_en) begin
                    w_state_nxt = ST_PARITY;
                end
`endif
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                w_ser_valid = 1'b1;
                w_ser_out   = r_par;
                w_last      = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Final bit consumed: chain the next word if one is waiting,
        // otherwise return to IDLE with the shift path cleared.
        if (w_frame_end) begin
            w_ready   = !rst;
            w_load    = 1'b1;
            w_cnt_nxt = '0;
            if (bus.in_valid) begin
                w_load_data = bus.in_data;
                w_state_nxt = ST_SHIFT;
            end else begin
                w_load_data = '0;
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.ser_valid = w_ser_valid;
    assign bus.ser_out   = w_ser_out;
    assign bus.ser_first = w_first;
    assign bus.ser_last  = w_last;
    assign busy          = (r_state != ST_IDLE);

endmodule
